// File: rtl/fb_write_scheduler.sv
// rtl/fb_write_scheduler.sv - frame-buffer write scheduler for full-screen clear and brush stamps (option: FB_SCHED_CLEAR_PREEMPT_EN)
module fb_write_scheduler #(
    parameter int W_RES = 640,
    parameter int H_RES = 480,
    parameter int SIZE  = 8,
    parameter int CW    = 11
) (
    input  logic          clock,
    input  logic          reset,
    input  logic          clear_req,
    input  logic          brush_req,
    input  logic [CW-1:0] brush_x,
    input  logic [CW-1:0] brush_y,
    input  logic [7:0]    brush_r,
    input  logic [7:0]    brush_g,
    input  logic [7:0]    brush_b,
    input  logic          wr_ready,
    output logic          wr_en,
    output logic [CW-1:0] wr_x,
    output logic [CW-1:0] wr_y,
    output logic [7:0]    wr_r,
    output logic [7:0]    wr_g,
    output logic [7:0]    wr_b,
    output logic          busy,
    output logic          clear_done,
    output logic          brush_done
);

    typedef enum logic [1:0] {S_IDLE, S_CLEAR, S_BRUSH, S_DONE} state_t;

    localparam logic [CW:0] W_LAST = (CW+1)'(W_RES - 1);
    localparam logic [CW:0] H_LAST = (CW+1)'(H_RES - 1);
    localparam logic [CW:0] SZ_M1  = (CW+1)'(SIZE - 1);

    state_t state, state_d;

    logic          clr_pend, br_pend;
    logic          clipped_q;
    logic          more;
    logic [CW-1:0] cx, cy, x0, x_end, y_end;
    logic [7:0]    col_r, col_g, col_b;

    // Stamp extents are evaluated one bit wider so bx+SIZE never wraps.
    logic [CW:0]   bx_ext, by_ext, bx_sum, by_sum, bx_lim, by_lim;
    logic          brush_clip;

    assign bx_ext     = {1'b0, brush_x};
    assign by_ext     = {1'b0, brush_y};
    assign bx_sum     = bx_ext + SZ_M1;
    assign by_sum     = by_ext + SZ_M1;
    assign bx_lim     = (bx_sum > W_LAST) ? W_LAST : bx_sum;
    assign by_lim     = (by_sum > H_LAST) ? H_LAST : by_sum;
    assign brush_clip = (bx_ext > W_LAST) || (by_ext > H_LAST);

    logic accepted, slot_free, last_acc, abort;

    assign accepted  = wr_en && wr_ready;
    assign slot_free = !wr_en || wr_ready;
    assign last_acc  = accepted && !more;

`ifdef FB_SCHED_CLEAR_PREEMPT_EN
    // A pending clear cuts a stamp short, but only on a beat boundary.
    assign abort = (state == S_BRUSH) && clr_pend && slot_free && !last_acc;
`else
    assign abort = 1'b0;
`endif

    always_ff @(posedge clock) begin
        if (reset) state <= S_IDLE;
        else       state <= state_d;
    end

    always_comb begin
        state_d = state;
        case (state)
            S_IDLE: begin
                if (clr_pend)     state_d = S_CLEAR;
                else if (br_pend) state_d = S_BRUSH;
            end
            S_CLEAR: begin
                if (last_acc) state_d = S_DONE;
            end
            S_BRUSH: begin
                if (clipped_q || last_acc) state_d = S_DONE;
                else if (abort)            state_d = S_CLEAR;
            end
            S_DONE:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    logic grant_clr, grant_br, issue, clear_done_d, brush_done_d, busy_d;

    always_comb begin
        grant_clr    = (state != S_CLEAR) && (state_d == S_CLEAR);
        grant_br     = (state == S_IDLE) && (state_d == S_BRUSH);
        issue        = ((state == S_CLEAR) || (state == S_BRUSH)) && (state_d == state)
                       && slot_free && more;
        clear_done_d = (state == S_CLEAR) && (state_d == S_DONE);
        brush_done_d = (state == S_BRUSH) && (state_d == S_DONE);
        busy_d       = (state_d != S_IDLE);
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            clr_pend   <= 1'b0;
            br_pend    <= 1'b0;
            clipped_q  <= 1'b0;
            more       <= 1'b0;
            cx         <= '0;
            cy         <= '0;
            x0         <= '0;
            x_end      <= '0;
            y_end      <= '0;
            col_r      <= '0;
            col_g      <= '0;
            col_b      <= '0;
            wr_en      <= 1'b0;
            wr_x       <= '0;
            wr_y       <= '0;
            wr_r       <= '0;
            wr_g       <= '0;
            wr_b       <= '0;
            busy       <= 1'b0;
            clear_done <= 1'b0;
            brush_done <= 1'b0;
        end else begin
            busy       <= busy_d;
            clear_done <= clear_done_d;
            brush_done <= brush_done_d;

            if (grant_clr)                             clr_pend <= 1'b0;
            else if (clear_req && (state != S_CLEAR))  clr_pend <= 1'b1;

            if (grant_br)       br_pend <= 1'b0;
            else if (brush_req) br_pend <= 1'b1;

            if (grant_clr) begin
                x0        <= '0;
                x_end     <= W_LAST[CW-1:0];
                y_end     <= H_LAST[CW-1:0];
                cx        <= '0;
                cy        <= '0;
                more      <= 1'b1;
                clipped_q <= 1'b0;
                col_r     <= '0;
                col_g     <= '0;
                col_b     <= '0;
            end else if (grant_br) begin
                x0        <= brush_x;
                x_end     <= bx_lim[CW-1:0];
                y_end     <= by_lim[CW-1:0];
                cx        <= brush_x;
                cy        <= brush_y;
                more      <= !brush_clip;
                clipped_q <= brush_clip;
                col_r     <= brush_r;
                col_g     <= brush_g;
                col_b     <= brush_b;
            end else if (issue) begin
                if (cx == x_end) begin
                    if (cy == y_end) begin
                        more <= 1'b0;
                    end else begin
                        cx <= x0;
                        cy <= cy + 1'b1;
                    end
                end else begin
                    cx <= cx + 1'b1;
                end
            end

            if (issue) begin
                wr_en <= 1'b1;
                wr_x  <= cx;
                wr_y  <= cy;
                wr_r  <= col_r;
                wr_g  <= col_g;
                wr_b  <= col_b;
            end else if (slot_free) begin
                wr_en <= 1'b0;
            end
        end
    end

endmodule
